// File: rtl/cavlc_pkg.sv
// Shared CAVLC constants and enums for the coeff_token stage.
package cavlc_pkg;
  localparam int TC_W   = 5;
  localparam int CODE_W = 16;
  localparam int LEN_W  = 5;
  localparam int MAX_TC = 16;

  typedef enum logic [2:0] {
    VLC0      = 3'd0,
    VLC1      = 3'd1,
    VLC2      = 3'd2,
    VLC3      = 3'd3,
    CHROMA_DC = 3'd4
  } tbl_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NC   = 2'd1,
    LOOK = 2'd2,
    OUT  = 2'd3
  } state_e;
endpackage

// File: rtl/coeff_token_nc_calc.sv
// Combinational nC derivation from neighbour counts and VLC table selection.
// CT_CHROMA_DC_EN routes ChromaDC blocks to their dedicated table.
module coeff_token_nc_calc
  import cavlc_pkg::*;
(
  input  logic [TC_W-1:0] n_a,
  input  logic [TC_W-1:0] n_b,
  input  logic            avail_a,
  input  logic            avail_b,
  input  logic            chroma_dc,
  output tbl_sel_e        sel
);
  logic [TC_W:0] nc;

  always_comb begin
    nc = '0;
    if (avail_a && avail_b)
      nc = ({1'b0, n_a} + {1'b0, n_b} + (TC_W+1)'(1)) >> 1;
    else if (avail_a)
      nc = {1'b0, n_a};
    else if (avail_b)
      nc = {1'b0, n_b};

    if (nc < (TC_W+1)'(2))      sel = VLC0;
    else if (nc < (TC_W+1)'(4)) sel = VLC1;
    else if (nc < (TC_W+1)'(8)) sel = VLC2;
    else                        sel = VLC3;
`ifdef CT_CHROMA_DC_EN
    // nC = -1 for ChromaDC: overrides the neighbour-derived table
    if (chroma_dc) sel = CHROMA_DC;
`endif
  end

`ifndef CT_CHROMA_DC_EN
  logic unused_chroma_dc;
  assign unused_chroma_dc = chroma_dc;
`endif
endmodule

// File: rtl/coeff_token_ctrl.sv
// CAVLC coeff_token sequencer: nC/table select, ROM handshake, inline nC>=8 code,
// valid/ready output and bit statistics. Optional ChromaDC table via CT_CHROMA_DC_EN.
module coeff_token_ctrl #(
  parameter int TC_W   = cavlc_pkg::TC_W,
  parameter int CODE_W = cavlc_pkg::CODE_W,
  parameter int LEN_W  = cavlc_pkg::LEN_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TC_W-1:0]   total_coeff,
  input  logic [1:0]        trailing_ones,
  input  logic [TC_W-1:0]   n_a,
  input  logic [TC_W-1:0]   n_b,
  input  logic              avail_a,
  input  logic              avail_b,
  input  logic              chroma_dc,
  output logic [2:0]        tbl_sel,
  output logic [6:0]        tbl_addr,
  input  logic [CODE_W-1:0] tbl_code,
  input  logic [LEN_W-1:0]  tbl_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_err,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  bit_count
);
  import cavlc_pkg::*;

  state_e          state_q, state_d;
  logic [TC_W-1:0] tc_q, na_q, nb_q;
  logic [1:0]      t1_q;
  logic            aa_q, ab_q, cd_q;
  tbl_sel_e        sel_w;
  logic            illegal;
  logic [3:0]      tc_m1;

  coeff_token_nc_calc u_nc (
    .n_a       (na_q),
    .n_b       (nb_q),
    .avail_a   (aa_q),
    .avail_b   (ab_q),
    .chroma_dc (cd_q),
    .sel       (sel_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = NC;
      NC:      state_d = LOOK;
      LOOK:    state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);

  always_comb begin
    illegal = (tc_q > TC_W'(MAX_TC)) || (TC_W'(t1_q) > tc_q);
`ifdef CT_CHROMA_DC_EN
    if (cd_q && (tc_q > TC_W'(4))) illegal = 1'b1;
`endif
  end

  // TotalCoeff=16 wraps to 4'hF, which is the intended 6-bit FLC code
  assign tc_m1 = tc_q[3:0] - 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q <= '0; na_q <= '0; nb_q <= '0; t1_q <= '0;
      aa_q <= 1'b0; ab_q <= 1'b0; cd_q <= 1'b0;
      tbl_sel <= '0; tbl_addr <= '0;
      out_code <= '0; out_len <= '0; out_err <= 1'b0;
      bit_count <= '0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        tc_q <= total_coeff; t1_q <= trailing_ones;
        na_q <= n_a; nb_q <= n_b;
        aa_q <= avail_a; ab_q <= avail_b; cd_q <= chroma_dc;
      end
      if (state_q == NC) begin
        tbl_sel  <= 3'(sel_w);
        tbl_addr <= {t1_q, tc_q};
      end
      if (state_q == LOOK) begin
        if (illegal) begin
          out_code <= '0;
          out_len  <= '0;
          out_err  <= 1'b1;
        end else if (tbl_sel == 3'(VLC3)) begin
          out_code <= (tc_q == '0) ? CODE_W'(6'b000011) : CODE_W'({tc_m1, t1_q});
          out_len  <= LEN_W'(6);
          out_err  <= 1'b0;
        end else begin
          out_code <= tbl_code;
          out_len  <= tbl_len;
          out_err  <= 1'b0;
        end
      end
      if (clr_stats)
        bit_count <= '0;
      else if (out_valid && out_ready)
        bit_count <= bit_count + CNT_W'(out_len);
    end
  end
endmodule

// File: doc/coeff_token_ctrl.md
Name: coeff_token_ctrl

Overview:
Sequencer for the CAVLC coeff_token stage of the H.264 encoder.
- Accepts one 4x4 block descriptor per transaction: TotalCoeff, TrailingOnes, and neighbour nA/nB with availability flags.
- Derives nC, selects the VLC table and drives the shared table-ROM address/select bus.
- Registers the returned codeword/length and hands it to the bitstream packer over a valid/ready handshake.
- Handles the fixed-length 6-bit nC>=8 table in-line; the ROMs for tables 0..2 (and optionally ChromaDC) are external combinational lookups.

Parameters:
- TC_W, 5, width of TotalCoeff and nA/nB (values 0..16).
- CODE_W, 16, maximum codeword width.
- LEN_W, 5, codeword length width (0..16).
- CNT_W, 32, width of the accumulated-bit statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  controller can accept a descriptor.
- total_coeff  in  TC_W  TotalCoeff, legal 0..16.
- trailing_ones  in  2  TrailingOnes, legal 0..min(3,TotalCoeff).
- n_a  in  TC_W  left-neighbour TotalCoeff.
- n_b  in  TC_W  top-neighbour TotalCoeff.
- avail_a  in  1  left neighbour available.
- avail_b  in  1  top neighbour available.
- chroma_dc  in  1  block is ChromaDC (used only with CT_CHROMA_DC_EN).
- tbl_sel  out  3  table select: 0..3 = numVlc 0..3, 4 = ChromaDC.
- tbl_addr  out  7  {trailing_ones, total_coeff}.
- tbl_code  in  CODE_W  ROM codeword, right-aligned.
- tbl_len  in  LEN_W  ROM codeword length.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_code  out  CODE_W  codeword, right-aligned.
- out_len  out  LEN_W  codeword length.
- out_err  out  1  descriptor was illegal.
- clr_stats  in  1  synchronous clear of bit_count.
- bit_count  out  CNT_W  sum of out_len over all accepted outputs.

Behaviour:
Reset: the following are all zero; state returns to IDLE. Reset mid-transaction discards the descriptor with no output.
- Outputs: out_valid, out_code, out_len, out_err, tbl_sel, tbl_addr, bit_count.
- in_ready = 1 after reset.

FSM states IDLE -> NC -> LOOK -> OUT -> IDLE:
- IDLE: in_ready=1. On in_valid, capture all inputs and go to NC.
- NC: compute nC.
  - Both available: (n_a+n_b+1)>>1, computed TC_W+1 wide.
  - Only A available: n_a. Only B available: n_b. Neither: 0.
  - Table select: nC 0..1 -> 0; 2..3 -> 1; 4..7 -> 2; >=8 -> 3.
  - Register tbl_sel and tbl_addr. Go to LOOK.
- LOOK: tbl_sel and tbl_addr stay stable this cycle; sample tbl_code/tbl_len at the end of the cycle.
  - tbl_sel=3: ignore the ROM and form the result in-line, length 6.
    - total_coeff=0 -> code 6'b000011.
    - Otherwise -> code {total_coeff-1 [3:0], trailing_ones}.
  - Go to OUT.
- OUT: out_valid=1; out_code, out_len and out_err are held stable until out_ready.
  - On out_valid && out_ready: add out_len to bit_count, then go to IDLE.
  - in_ready=0 throughout NC/LOOK/OUT (no overlap).

Timing and counters:
- Latency: accept at edge N -> out_valid visible after edge N+3 (one cycle each in NC and LOOK). Minimum 4 cycles per descriptor.
- Illegal descriptor (total_coeff>16, or trailing_ones>total_coeff): out_err=1, out_code=0, out_len=0. The handshake completes normally and bit_count is unchanged.
- bit_count wraps modulo 2^CNT_W.
- clr_stats has priority over a simultaneous accumulate: the counter becomes 0, and the concurrent length is dropped.
- tbl_sel/tbl_addr hold their last value in IDLE.

Optional Feature:
CT_CHROMA_DC_EN
- Defined: a captured chroma_dc=1 forces nC=-1 and tbl_sel=4. The ROM result is used.
  - Legal only with total_coeff<=4; total_coeff>4 flags out_err.
- Undefined: chroma_dc is ignored and tbl_sel never equals 4.

Decomposition:
Shared package cavlc_pkg holds:
- TC_W, CODE_W and LEN_W constants.
- Table-select enum (VLC0, VLC1, VLC2, VLC3, CHROMA_DC).
- FSM state enum.
- Max-TotalCoeff constant 16.

One natural sub-module, coeff_token_nc_calc: purely combinational nC derivation and table selection. The FSM, in-line VLC3 formatting and statistics counter stay in the top level.

Test Plan:
- avail_a=1, avail_b=1, n_a=3, n_b=4, tc=2, t1=1 -> tbl_sel=2, tbl_addr=7'b01_00010; out_code/out_len equal the ROM model; out_valid 3 cycles after accept.
- avail_a=1, avail_b=0, n_a=10, tc=0 -> tbl_sel=3, out_code=6'b000011, out_len=6; next descriptor with tc=5, t1=2 -> out_code=6'b010010, out_len=6.
- tc=1, t1=2 -> out_err=1, out_len=0; bit_count unchanged.
- out_ready held low 5 cycles in OUT -> out_* stable and in_ready=0 throughout; bit_count increments exactly once on release.
- rst_n asserted during LOOK -> all outputs 0 immediately, no out_valid; the next descriptor after release processes normally.
- clr_stats asserted in the same cycle as an out_len=6 handshake -> bit_count=0; with CT_CHROMA_DC_EN, chroma_dc=1, tc=2 -> tbl_sel=4.
